// File: rtl/rll_ctrl_pkg.sv
// Shared types and helpers for the RLL key loader: state encoding, default
// widths and the chunk checksum step.
package rll_ctrl_pkg;

  localparam int RLL_KEY_W   = 32;
  localparam int RLL_CHUNK_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    ACTIVE,
    LOCKOUT
  } rll_ld_state_t;

  function automatic logic [RLL_CHUNK_W-1:0] xor_chk(
    input logic [RLL_CHUNK_W-1:0] acc,
    input logic [RLL_CHUNK_W-1:0] data
  );
    return acc ^ data;
  endfunction

endpackage

// File: rtl/rll_key_shadow.sv
// Shadow key register filled chunk by chunk, with a write counter and a
// running XOR checksum of everything written since the last clear.
module rll_key_shadow
  import rll_ctrl_pkg::*;
#(
  parameter int KEY_W   = RLL_KEY_W,
  parameter int CHUNK_W = RLL_CHUNK_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               wr_en,
  input  logic [CHUNK_W-1:0] wr_data,
  output logic               full,
  output logic [CHUNK_W-1:0] acc,
  output logic [KEY_W-1:0]   shadow
);

  localparam int N  = KEY_W / CHUNK_W;
  localparam int CW = $clog2(N + 1);

  logic [CW-1:0]      r_cnt;
  logic [CHUNK_W-1:0] r_acc;
  logic [KEY_W-1:0]   r_shadow;
  logic [CHUNK_W-1:0] w_acc_nxt;

  generate
    if (CHUNK_W == RLL_CHUNK_W) begin : g_pkg_chk
      assign w_acc_nxt = xor_chk(r_acc, wr_data);
    end else begin : g_wide_chk
      assign w_acc_nxt = r_acc ^ wr_data;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_shadow <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < N; k++) begin
        if (r_cnt == CW'(k)) r_shadow[k*CHUNK_W +: CHUNK_W] <= wr_data;
      end
      r_cnt <= r_cnt + CW'(1);
      r_acc <= w_acc_nxt;
    end
  end

  // High while the next write lands in the last slot.
  assign full   = (r_cnt == CW'(N - 1));
  assign acc    = r_acc;
  assign shadow = r_shadow;

endmodule

// File: rtl/rll_key_loader.sv
// Streams a locking key in chunks, verifies its XOR checksum and drives the
// verified key to the locked netlist; repeated failures latch a lockout.
//   state   | meaning
//   IDLE    | no key, waiting for start
//   LOAD    | accepting key chunks into the shadow register
//   CHECK   | next chunk is the checksum
//   ACTIVE  | verified key driven on key_out
//   LOCKOUT | MAX_FAIL consecutive failures, only rst exits
module rll_key_loader
  import rll_ctrl_pkg::*;
#(
  parameter int KEY_W    = RLL_KEY_W,
  parameter int CHUNK_W  = RLL_CHUNK_W,
  parameter int MAX_FAIL = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CHUNK_W-1:0] kin_data,
  input  logic               kin_valid,
  output logic               kin_ready,
  output logic [KEY_W-1:0]   key_out,
  output logic               key_valid,
  output logic               busy,
  output logic               err,
  output logic               lockout
);

  localparam int FW = $clog2(MAX_FAIL + 1);

  rll_ld_state_t      r_state;
  logic [FW-1:0]      r_fail_cnt;
  logic [KEY_W-1:0]   r_key_out;
  logic               r_key_valid;
  logic               r_err;
  logic               r_lockout;

  logic [FW-1:0]      w_fail_nxt;
  logic               w_xfer;
  logic               w_clr;
  logic               w_wr_en;
  logic               w_full;
  logic [CHUNK_W-1:0] w_acc;
  logic [KEY_W-1:0]   w_shadow;

  assign kin_ready  = (r_state == LOAD) || (r_state == CHECK);
  assign busy       = kin_ready;
  assign w_xfer     = kin_valid && kin_ready;
  assign w_clr      = start && ((r_state == IDLE) || (r_state == ACTIVE));
  assign w_wr_en    = w_xfer && (r_state == LOAD);
  assign w_fail_nxt = r_fail_cnt + FW'(1);

  rll_key_shadow #(
    .KEY_W   (KEY_W),
    .CHUNK_W (CHUNK_W)
  ) u_shadow (
    .clk     (clk),
    .rst     (rst),
    .clr     (w_clr),
    .wr_en   (w_wr_en),
    .wr_data (kin_data),
    .full    (w_full),
    .acc     (w_acc),
    .shadow  (w_shadow)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_fail_cnt  <= '0;
      r_key_out   <= '0;
      r_key_valid <= 1'b0;
      r_err       <= 1'b0;
      r_lockout   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) r_state <= LOAD;
        end
        LOAD: begin
          if (w_xfer && w_full) r_state <= CHECK;
        end
        CHECK: begin
          if (w_xfer) begin
            if (kin_data == w_acc) begin
              r_key_out   <= w_shadow;
              r_key_valid <= 1'b1;
              r_fail_cnt  <= '0;
              r_state     <= ACTIVE;
            end else begin
              r_err      <= 1'b1;
              r_fail_cnt <= w_fail_nxt;
              if (w_fail_nxt == FW'(MAX_FAIL)) begin
                r_lockout <= 1'b1;
                r_state   <= LOCKOUT;
              end else begin
                r_state <= IDLE;
              end
            end
          end
        end
        ACTIVE: begin
          // Drop the old key before the first new chunk can arrive.
          if (start) begin
            r_key_out   <= '0;
            r_key_valid <= 1'b0;
            r_state     <= LOAD;
          end
        end
        LOCKOUT: begin
          r_key_out   <= '0;
          r_key_valid <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign key_out   = r_key_out;
  assign key_valid = r_key_valid;
  assign err       = r_err;
  assign lockout   = r_lockout;

endmodule

// File: tb/tb_rll_key_loader.sv
// Self-checking bench for rll_key_loader: vector table of key loads, a
// scoreboard of expected check outcomes, and hand-written corner sequences.
module tb_rll_key_loader;

  localparam logic [31:0] NET_KEY = 32'hF00F3CA5;

  typedef struct {
    logic [31:0] key;
    logic [7:0]  chk;
    bit          bp;
    bit          exp_ok;
    logic [31:0] exp_key;
  } vec_t;

  typedef struct {
    bit          ok;
    logic [31:0] key;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  kin_data;
  logic        kin_valid;
  logic        kin_ready;
  logic [31:0] key_out;
  logic        key_valid;
  logic        busy;
  logic        err;
  logic        lockout;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];
  vec_t vecs[7];

  always #5 clk = ~clk;

  rll_key_loader #(.KEY_W(32), .CHUNK_W(8), .MAX_FAIL(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .kin_data  (kin_data),
    .kin_valid (kin_valid),
    .kin_ready (kin_ready),
    .key_out   (key_out),
    .key_valid (key_valid),
    .busy      (busy),
    .err       (err),
    .lockout   (lockout)
  );

  // Locked benchmark model: keyIn_0_i is key_out[i]; key gates sit on the
  // 32 internal nets, transparent only for the correct key.
  function automatic logic [31:0] net_int(input logic [15:0] x);
    return {x, ~x} ^ {x[3:0], x[15:4], x[11:0], x[15:12]};
  endfunction

  function automatic logic [7:0] net_core(input logic [31:0] n);
    return n[7:0] ^ n[15:8] ^ (n[23:16] & n[31:24]);
  endfunction

  function automatic logic [7:0] net_golden(input logic [15:0] x);
    return net_core(net_int(x));
  endfunction

  function automatic logic [7:0] net_locked(input logic [15:0] x, input logic [31:0] keyIn_0);
    return net_core(net_int(x) ^ keyIn_0 ^ NET_KEY);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic xfer(input logic [7:0] d, output bit ok);
    ok        = 1'b0;
    kin_data  = d;
    kin_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (kin_ready) begin
        @(negedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    kin_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_result(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_key_valid"}, {31'd0, key_valid}, {31'd0, e.ok});
    chk({tag, "_err"}, {31'd0, err}, {31'd0, !e.ok});
    chk({tag, "_key_out"}, key_out, e.ok ? e.key : 32'd0);
    @(negedge clk);
    chk({tag, "_err_pulse"}, {31'd0, err}, 32'd0);
    chk({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
    if (!e.ok) chk({tag, "_kin_ready_after"}, {31'd0, kin_ready}, 32'd0);
  endtask

  task automatic do_load(input logic [31:0] key, input logic [7:0] cs, input bit bp,
                         input bit exp_ok, input logic [31:0] exp_key, input string tag);
    bit   was_active;
    bit   ok;
    exp_t e;
    was_active = key_valid;
    pulse_start();
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    if (was_active) begin
      chk({tag, "_reload_key_out"}, key_out, 32'd0);
      chk({tag, "_reload_key_valid"}, {31'd0, key_valid}, 32'd0);
    end
    for (int k = 0; k < 4; k++) begin
      if (bp) @(negedge clk);
      xfer(key[k*8 +: 8], ok);
      chk({tag, "_chunk_xfer"}, {31'd0, ok}, 32'd1);
    end
    if (bp) @(negedge clk);
    chk({tag, "_key_hidden"}, key_out, 32'd0);
    e.ok  = exp_ok;
    e.key = exp_key;
    sb.push_back(e);
    xfer(cs, ok);
    chk({tag, "_chk_xfer"}, {31'd0, ok}, 32'd1);
    check_result(tag);
  endtask

  initial begin
    bit ok;
    int diffs;
    logic [15:0] x;

    vecs[0] = '{32'hF00F3CA5, 8'h66, 1'b0, 1'b1, 32'hF00F3CA5};
    vecs[1] = '{32'hF00F3CA5, 8'h66, 1'b1, 1'b1, 32'hF00F3CA5};
    vecs[2] = '{32'hF00F3CA5, 8'h00, 1'b0, 1'b0, 32'h00000000};
    vecs[3] = '{32'h12345678, 8'h08, 1'b1, 1'b1, 32'h12345678};
    vecs[4] = '{32'hFFFFFFFF, 8'hFF, 1'b0, 1'b0, 32'h00000000};
    vecs[5] = '{32'h00000000, 8'h01, 1'b0, 1'b0, 32'h00000000};
    vecs[6] = '{32'h80000001, 8'h81, 1'b0, 1'b1, 32'h80000001};

    rst = 1'b1; start = 1'b0; kin_data = 8'h00; kin_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_key_out", key_out, 32'd0);
    chk("rst_key_valid", {31'd0, key_valid}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_lockout", {31'd0, lockout}, 32'd0);
    chk("rst_kin_ready", {31'd0, kin_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    // Data offered in IDLE is not consumed.
    xfer(8'hA5, ok);
    chk("idle_no_xfer", {31'd0, ok}, 32'd0);

    // Two failures then a success: success must clear the fail count.
    for (int i = 0; i < 7; i++)
      do_load(vecs[i].key, vecs[i].chk, vecs[i].bp, vecs[i].exp_ok, vecs[i].exp_key,
              $sformatf("vec%0d", i));
    chk("vec_lockout_clear", {31'd0, lockout}, 32'd0);

    for (int i = 0; i < 3; i++) begin
      do_load(32'hF00F3CA5, 8'h00, 1'b0, 1'b0, 32'd0, $sformatf("bad%0d", i));
      chk($sformatf("lockout_after_bad%0d", i), {31'd0, lockout}, {31'd0, i == 2});
    end
    pulse_start();
    chk("lk_kin_ready", {31'd0, kin_ready}, 32'd0);
    xfer(8'hA5, ok);
    chk("lk_no_xfer", {31'd0, ok}, 32'd0);
    chk("lk_key_out", key_out, 32'd0);
    chk("lk_key_valid", {31'd0, key_valid}, 32'd0);
    chk("lk_busy", {31'd0, busy}, 32'd0);
    chk("lk_sticky", {31'd0, lockout}, 32'd1);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("lk_rst_lockout", {31'd0, lockout}, 32'd0);
    chk("lk_rst_kin_ready", {31'd0, kin_ready}, 32'd0);

    do_load(32'hF00F3CA5, 8'h11, 1'b0, 1'b0, 32'd0, "pre1");
    do_load(32'hF00F3CA5, 8'h22, 1'b0, 1'b0, 32'd0, "pre2");
    pulse_start();
    xfer(8'hA5, ok);
    xfer(8'h3C, ok);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    kin_data = 8'h0F; kin_valid = 1'b1; rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0; kin_valid = 1'b0;
    chk("mid_rst_key_out", key_out, 32'd0);
    chk("mid_rst_key_valid", {31'd0, key_valid}, 32'd0);
    chk("mid_rst_err", {31'd0, err}, 32'd0);
    chk("mid_rst_lockout", {31'd0, lockout}, 32'd0);
    chk("mid_rst_kin_ready", {31'd0, kin_ready}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);

    diffs = 0;
    for (int i = 0; i < 200; i++) begin
      x = 16'($urandom_range(0, 65535));
      if (net_locked(x, key_out) !== net_golden(x)) diffs++;
    end
    chk("wrong_key_corrupts", {31'd0, diffs != 0}, 32'd1);

    // Fail count must have restarted from zero at rst.
    do_load(32'hF00F3CA5, 8'h33, 1'b0, 1'b0, 32'd0, "post1");
    do_load(32'hF00F3CA5, 8'h44, 1'b0, 1'b0, 32'd0, "post2");
    chk("post_rst_no_lockout", {31'd0, lockout}, 32'd0);
    do_load(32'hF00F3CA5, 8'h66, 1'b0, 1'b1, 32'hF00F3CA5, "fresh");

    diffs = 0;
    for (int i = 0; i < 1000; i++) begin
      x = 16'($urandom_range(0, 65535));
      if (net_locked(x, key_out) !== net_golden(x)) diffs++;
    end
    chk("equiv_mismatches", diffs, 32'd0);
    chk("sb_drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
